// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_arbiter
// Description : N-master to 1-slave round-robin arbiter for the native
//               valid/ready memory bus (valid, instr, ready, addr, wdata,
//               wstrb, rdata). One arbitration cycle in IDLE picks the next
//               requester after the last completed grant. The owner's request
//               is then forwarded combinationally to the slave until the slave
//               completes it.
//               Optional macro BUS_ARB_TIMEOUT_EN adds a BUSY watchdog. When
//               the watchdog fires, the owner gets a ready pulse carrying
//               ERR_DATA and err pulses for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_arbiter #(
    parameter int          NUM_MASTERS    = 2,
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int          STRB_W         = DATA_W / 8,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF,
    parameter int          GRANT_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    // master side
    input  logic [NUM_MASTERS-1:0]        m_valid,
    input  logic [NUM_MASTERS-1:0]        m_instr,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [DATA_W-1:0]             m_rdata,
    // slave side
    output logic                          s_valid,
    output logic                          s_instr,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [STRB_W-1:0]             s_wstrb,
    input  logic                          s_ready,
    input  logic [DATA_W-1:0]             s_rdata,
    // status
    output logic [GRANT_W-1:0]            grant_id,
    output logic                          busy,
    output logic                          err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_BUSY = 1'b1;

    // The pointer starts at the top master, so master 0 wins the first scan.
    localparam logic [GRANT_W-1:0] C_LAST_RESET = GRANT_W'(NUM_MASTERS - 1);

    // ERR_DATA is a 32-bit constant. The cast truncates it or zero-extends it
    // to the bus width.
    localparam logic [DATA_W-1:0] C_ERR_DATA = DATA_W'(ERR_DATA);

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [GRANT_W-1:0] r_grant;
    logic [GRANT_W-1:0] r_last;
    logic [GRANT_W-1:0] w_rr_pick;
    logic               w_any_req;

    // Per-master views of the packed request buses
    logic [ADDR_W-1:0]  w_addr_arr  [NUM_MASTERS];
    logic [DATA_W-1:0]  w_wdata_arr [NUM_MASTERS];
    logic [STRB_W-1:0]  w_wstrb_arr [NUM_MASTERS];

    // Request fields of the current owner
    logic               w_sel_valid;
    logic               w_sel_instr;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [STRB_W-1:0]  w_sel_wstrb;

    // Transaction-end qualifiers, valid only while BUSY
    logic               w_in_busy;
    logic               w_complete;   // slave finished, or the watchdog fired
    logic               w_abandon;    // owner dropped valid before completion
    logic               w_timeout;    // watchdog fires this cycle

    // ------------------------------------------------------------------------
    // Unpack the flat master buses into indexable arrays
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = m_addr [gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
            assign w_wstrb_arr[gi] = m_wstrb[gi*STRB_W +: STRB_W];
        end
    endgenerate

    // Pick the first requester strictly after 'last', wrapping once around the ring.
    function automatic logic [GRANT_W-1:0] f_rr_pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [GRANT_W-1:0]     last
    );
        logic [GRANT_W-1:0] pick;
        logic               found;
        int                 idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = GRANT_W'(idx);
            end
        end
        return pick;
    endfunction

    // Round-robin choice, evaluated every cycle and consumed only in IDLE
    always_comb begin
        w_any_req = |m_valid;
        w_rr_pick = f_rr_pick(m_valid, r_last);
    end

    // Select the owning master's request fields
    always_comb begin
        w_sel_valid = m_valid[r_grant];
        w_sel_instr = m_instr[r_grant];
        w_sel_addr  = w_addr_arr[r_grant];
        w_sel_wdata = w_wdata_arr[r_grant];
        w_sel_wstrb = w_wstrb_arr[r_grant];
    end

    assign w_in_busy = (r_state == C_ST_BUSY);

`ifdef BUS_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // BUSY watchdog
    // ------------------------------------------------------------------------
    localparam int                C_CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [C_CNT_W-1:0] r_tmo_cnt;

    // The counter is held at zero in IDLE, so every BUSY period starts from 0.
    // It advances on each BUSY cycle that does not complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (!w_in_busy) begin
            r_tmo_cnt <= '0;
        end else if (!s_ready) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // The watchdog fires only while the owner still requests. A real slave
    // completion in the same cycle takes priority.
    assign w_timeout = w_in_busy && w_sel_valid && !s_ready && (r_tmo_cnt == C_CNT_LAST);
`else
    // No watchdog, so BUSY waits for the slave indefinitely. The comparison
    // keeps TIMEOUT_CYCLES referenced, so both builds share one parameter list.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    assign w_complete = w_in_busy && (s_ready || w_timeout);
    assign w_abandon  = w_in_busy && !s_ready && !w_sel_valid;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // A reset in BUSY drops the transaction at the next edge without a ready pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // IDLE arbitrates whenever anyone requests. BUSY ends on a completion or
    // when the owner withdraws.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (w_any_req) begin
                    w_state_next = C_ST_BUSY;
                end
            end
            C_ST_BUSY: begin
                if (w_complete || w_abandon) begin
                    w_state_next = C_ST_IDLE;
                end
            end
            default: begin
                w_state_next = C_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Grant and round-robin pointer
    // ------------------------------------------------------------------------
    // The grant is latched when arbitration wins. The pointer advances only on
    // a completed transaction, so a withdrawn request leaves fairness unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_last  <= C_LAST_RESET;
        end else begin
            if ((r_state == C_ST_IDLE) && w_any_req) begin
                r_grant <= w_rr_pick;
            end
            if (w_complete) begin
                r_last <= r_grant;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    // In BUSY the owner is forwarded to the slave. The slave port is zeroed
    // elsewhere, so the decoder never sees stale addresses.
    always_comb begin
        s_valid = 1'b0;
        s_instr = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        m_ready = '0;
        m_rdata = '0;
        err     = 1'b0;
        if (r_state == C_ST_BUSY) begin
            // Retract the slave request in the cycle the watchdog aborts it.
            s_valid          = w_sel_valid && !w_timeout;
            s_instr          = w_sel_instr;
            s_addr           = w_sel_addr;
            s_wdata          = w_sel_wdata;
            s_wstrb          = w_sel_wstrb;
            m_ready[r_grant] = s_ready || w_timeout;
            m_rdata          = w_timeout ? C_ERR_DATA : s_rdata;
            err              = w_timeout;
        end
    end

    assign grant_id = r_grant;
    assign busy     = (r_state == C_ST_BUSY);

endmodule
`default_nettype wire

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- N-master to 1-slave arbiter for the native valid/ready memory bus: valid, instr, ready, addr, wdata, wstrb, rdata.
- Lets several initiators (core I-fetch, core D-port, DMA, vector unit) share one slave port (SRAM, peripheral fabric).
- Round-robin fairness; address/data widths parametrised.
- Sits between the masters and the address decoder.

Parameters:
- NUM_MASTERS, 2, number of master ports (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- STRB_W, DATA_W/8, write-strobe width (derived; do not override).
- TIMEOUT_CYCLES, 256, cycles in BUSY before a timeout abort (used only with the optional feature).
- ERR_DATA, 32'hDEADBEEF, rdata returned on a timeout abort, truncated/zero-extended to DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- m_valid  in  NUM_MASTERS  per-master request valid.
- m_instr  in  NUM_MASTERS  per-master instruction-fetch flag.
- m_addr  in  NUM_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  NUM_MASTERS*DATA_W  packed write data.
- m_wstrb  in  NUM_MASTERS*STRB_W  packed strobes; all-zero means read.
- m_ready  out  NUM_MASTERS  per-master completion pulse.
- m_rdata  out  DATA_W  shared read data; valid only with the matching m_ready bit.
- s_valid  out  1  slave request valid.
- s_instr  out  1  forwarded instr flag.
- s_addr  out  ADDR_W  forwarded address.
- s_wdata  out  DATA_W  forwarded write data.
- s_wstrb  out  STRB_W  forwarded strobes.
- s_ready  in  1  slave completion pulse.
- s_rdata  in  DATA_W  slave read data.
- grant_id  out  $clog2(NUM_MASTERS) (min 1)  index of the owning master; meaningful when busy=1.
- busy  out  1  a transaction is in flight.
- err  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- Protocol: a master holds valid, addr, wdata, wstrb and instr stable until it sees its ready pulse. Ready is high for exactly one cycle per transaction. rdata is sampled in the ready cycle.
- FSM: IDLE, BUSY.
- Reset state: IDLE. Outputs at reset: s_valid=0, m_ready=0, busy=0, err=0, grant_id=0. Last-grant pointer = NUM_MASTERS-1, so master 0 wins first. Timeout counter = 0.
- IDLE: if any m_valid bit is set, choose the first requester scanning upward from (last+1) mod NUM_MASTERS with wrap-around. Register grant_id, go to BUSY, set busy=1. If no bit is set, stay in IDLE.
- BUSY (combinational forwarding):
  - s_valid = m_valid[grant_id].
  - s_addr, s_wdata, s_wstrb, s_instr come from the granted master.
  - m_ready[grant_id] = s_ready; all other m_ready bits = 0.
  - m_rdata = s_rdata.
- BUSY exit:
  - s_ready=1: last := grant_id; go to IDLE; busy drops next cycle.
  - m_valid[grant_id]=0 before s_ready (protocol violation): go to IDLE, pointer unchanged, no ready issued.
- Latency: 1 arbitration cycle (IDLE to BUSY) plus the slave latency. One IDLE cycle always separates back-to-back transactions, so best-case throughput is 1 transaction per 2 cycles + slave latency.
- Simultaneous requests: exactly one grant. Round-robin guarantees each persistent requester is served within NUM_MASTERS transactions.
- Outside BUSY: s_valid=0; s_addr, s_wdata, s_wstrb and s_instr = 0.
- Reset mid-transaction: return to IDLE next edge; s_valid drops; no m_ready is issued for the aborted request.
- A new request arriving in the same cycle as s_ready is considered in the following IDLE cycle.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to BUSY and increments every BUSY cycle without s_ready.
  - When the count reaches TIMEOUT_CYCLES-1 with s_ready still low, that cycle drives m_ready[grant_id]=1, m_rdata=ERR_DATA, err=1, s_valid=0.
  - Then go to IDLE and update the pointer as for a normal completion.
  - If s_ready arrives in that same cycle, normal completion wins and err stays 0.
- Undefined: no counter logic; BUSY waits indefinitely; err tied to 0.

Test Plan:
- Reset, then m_valid=2'b01, addr 0x100, slave ready after 3 cycles with rdata 0x12345678 -> s_valid rises 1 cycle after request; m_ready[0] pulses once with m_rdata=0x12345678; busy returns to 0.
- Masters 0 and 1 both request continuously (NUM_MASTERS=2) -> grants alternate 0,1,0,1 over 4 transactions; m_ready never hits both bits in one cycle.
- NUM_MASTERS=4, masters 1 and 3 request after a grant to 2 -> master 3 is served before master 1.
- Master 0 write, wstrb=4'b0011, wdata=0xAABBCCDD -> s_wstrb=4'b0011 and s_wdata=0xAABBCCDD held stable until s_ready.
- rst asserted mid-BUSY -> next cycle s_valid=0, busy=0, no m_ready; the following request goes to master 0.
- BUS_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, slave never ready -> in the 8th BUSY cycle m_ready pulses with m_rdata=0xDEADBEEF and err=1; arbiter back in IDLE.
